// File: rtl/muldiv_ctrl.sv
// Purpose : multi-cycle MULT/MULTU/DIV/DIVU sequencer for the execute stage, HI/LO result.
// Latency : multiply writes 2 cycles after issue, divide 33, divide-by-zero 1.
// Backpress: stall_o holds the pipeline while busy; stall_ext_i defers the single HILO write.
//
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   start_i           - EX instruction is mul/div (stays high until EX advances)
//   op_i[1:0]         - 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   srca_i, srcb_i    - rs (dividend/multiplicand), rt (divisor/multiplier)
//   flush_i           - EX squash, aborts any operation in flight
//   stall_ext_i       - pipeline held by another hazard; delays the write
//   stall_o           - stall request to the hazard unit
//   hilo_we_o[1:0]    - {HI we, LO we}, 2'b11 for exactly one cycle per result
//   hi_o, lo_o        - upper product / remainder, lower product / quotient
module muldiv_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic [1:0]  op_i,
  input  logic [31:0] srca_i,
  input  logic [31:0] srcb_i,
  input  logic        flush_i,
  input  logic        stall_ext_i,
  output logic        stall_o,
  output logic [1:0]  hilo_we_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t      state_q;
  logic        op_unsigned_q;   // op[0] of the latched instruction
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [31:0] rem_q;
  logic [31:0] quo_q;           // holds the dividend magnitude, shifted out as quotient shifts in
  logic [31:0] dvsr_q;
  logic        qneg_q;
  logic        rneg_q;
  logic [5:0]  cnt_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;

  logic        accept;
  logic        div_signed;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [63:0] ext_a;
  logic [63:0] ext_b;
  logic [63:0] prod;
  logic [32:0] shift_rem;
  logic [32:0] trial;
  logic [31:0] rem_d;
  logic [31:0] quo_d;

  // A start with flush in the same cycle is a squashed instruction: ignore it.
  assign accept = (state_q == S_IDLE) & start_i & ~flush_i;

  // Divide operand magnitudes are taken at issue, straight from the source operands.
  assign div_signed = ~op_i[0];
  assign mag_a = (div_signed & srca_i[31]) ? (~srca_i + 32'd1) : srca_i;
  assign mag_b = (div_signed & srcb_i[31]) ? (~srcb_i + 32'd1) : srcb_i;

  // Extending both operands to 64 bits makes one unsigned multiplier serve
  // both MULT and MULTU: the low 64 bits of the product are the same.
  assign ext_a = op_unsigned_q ? {32'd0, a_q} : {{32{a_q[31]}}, a_q};
  assign ext_b = op_unsigned_q ? {32'd0, b_q} : {{32{b_q[31]}}, b_q};
  assign prod  = ext_a * ext_b;

  // One restoring step. The shifted remainder needs 33 bits because the
  // divisor magnitude can be as large as 2^32-1; since rem < divisor before
  // the shift, a non-negative difference always fits in 32 bits, so bit 32
  // of the trial is a clean borrow flag.
  assign shift_rem = {rem_q, quo_q[31]};
  assign trial     = shift_rem - {1'b0, dvsr_q};

  always_comb begin
    rem_d = shift_rem[31:0];
    quo_d = {quo_q[30:0], 1'b0};
    if (!trial[32]) begin
      rem_d = trial[31:0];
      quo_d = {quo_q[30:0], 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      op_unsigned_q <= 1'b0;
      a_q           <= 32'd0;
      b_q           <= 32'd0;
      rem_q         <= 32'd0;
      quo_q         <= 32'd0;
      dvsr_q        <= 32'd0;
      qneg_q        <= 1'b0;
      rneg_q        <= 1'b0;
      cnt_q         <= 6'd0;
      hi_q          <= 32'd0;
      lo_q          <= 32'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            op_unsigned_q <= op_i[0];
            a_q           <= srca_i;
            b_q           <= srcb_i;
            if (!op_i[1]) begin
              state_q <= S_MUL;
            end else if (srcb_i == 32'd0) begin
              // Divide by zero: fixed all-ones quotient, dividend as remainder.
              hi_q    <= srca_i;
              lo_q    <= 32'hFFFF_FFFF;
              state_q <= S_DONE;
            end else begin
              rem_q   <= 32'd0;
              quo_q   <= mag_a;
              dvsr_q  <= mag_b;
              qneg_q  <= div_signed & (srca_i[31] ^ srcb_i[31]);
              rneg_q  <= div_signed & srca_i[31];
              cnt_q   <= 6'd0;
              state_q <= S_DIV;
            end
          end
        end

        S_MUL: begin
          if (flush_i) begin
            state_q <= S_IDLE;
          end else begin
            hi_q    <= prod[63:32];
            lo_q    <= prod[31:0];
            state_q <= S_DONE;
          end
        end

        S_DIV: begin
          if (flush_i) begin
            state_q <= S_IDLE;
          end else begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            cnt_q <= cnt_q + 6'd1;
            if (cnt_q == 6'd31) begin
              // Sign fixup on the final step's results. 0x80000000 / -1 falls
              // out naturally: magnitude quotient 0x80000000, qneg clear.
              hi_q    <= rneg_q ? (~rem_d + 32'd1) : rem_d;
              lo_q    <= qneg_q ? (~quo_d + 32'd1) : quo_d;
              state_q <= S_DONE;
            end
          end
        end

        S_DONE: begin
          // start_i is still high here (same instruction in EX) and must not
          // restart; leaving only happens on the write or a flush.
          if (flush_i || !stall_ext_i) begin
            state_q <= S_IDLE;
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign stall_o   = ~rst & (accept | (state_q == S_MUL) | (state_q == S_DIV));
  assign hilo_we_o = {2{~rst & (state_q == S_DONE) & ~stall_ext_i & ~flush_i}};
  assign hi_o      = hi_q;
  assign lo_o      = lo_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Randomised and directed bench for muldiv_ctrl against a plain-arithmetic reference.
module tb_muldiv_ctrl;

  logic        clk;
  logic        rst;
  logic        start_i;
  logic [1:0]  op_i;
  logic [31:0] srca_i;
  logic [31:0] srcb_i;
  logic        flush_i;
  logic        stall_ext_i;
  logic        stall_o;
  logic [1:0]  hilo_we_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;

  int n_vec;
  int n_err;

  muldiv_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start_i),
    .op_i        (op_i),
    .srca_i      (srca_i),
    .srcb_i      (srcb_i),
    .flush_i     (flush_i),
    .stall_ext_i (stall_ext_i),
    .stall_o     (stall_o),
    .hilo_we_o   (hilo_we_o),
    .hi_o        (hi_o),
    .lo_o        (lo_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: results by ordinary arithmetic, latency from the cycle budget
  // of each operation class.
  task automatic model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] hi, output logic [31:0] lo, output int lat);
    longint      sa;
    longint      sb;
    logic [63:0] p;
    logic [63:0] q64;
    logic [63:0] r64;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    hi = 32'd0;
    lo = 32'd0;
    lat = 0;
    if (!op[1]) begin
      if (op[0]) p = {32'd0, a} * {32'd0, b};
      else       p = sa * sb;
      hi  = p[63:32];
      lo  = p[31:0];
      lat = 2;
    end else if (b == 32'd0) begin
      hi  = a;
      lo  = 32'hFFFF_FFFF;
      lat = 1;
    end else begin
      if (op[0]) begin
        lo = a / b;
        hi = a % b;
      end else begin
        q64 = sa / sb;
        r64 = sa % sb;
        lo  = q64[31:0];
        hi  = r64[31:0];
      end
      lat = 33;
    end
  endtask

  // Issue one instruction, follow it cycle by cycle to its write, with an
  // optional external stall held for ext cycles once DONE is reached.
  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input int ext);
    logic [31:0] ehi;
    logic [31:0] elo;
    int          lat;
    model(op, a, b, ehi, elo, lat);
    @(posedge clk); #1;
    start_i = 1'b1;
    op_i    = op;
    srca_i  = a;
    srcb_i  = b;
    for (int k = 0; k < lat; k++) begin
      @(negedge clk);
      check_eq("busy_stall", {63'd0, stall_o}, 64'd1);
      check_eq("busy_we", {62'd0, hilo_we_o}, 64'd0);
      @(posedge clk); #1;
      // operands must have been latched at issue
      srca_i = $urandom;
      srcb_i = $urandom;
    end
    if (ext > 0) begin
      stall_ext_i = 1'b1;
      for (int j = 0; j < ext; j++) begin
        @(negedge clk);
        check_eq("ext_hold_we", {62'd0, hilo_we_o}, 64'd0);
        check_eq("ext_hold_stall", {63'd0, stall_o}, 64'd0);
        @(posedge clk); #1;
      end
      stall_ext_i = 1'b0;
    end
    @(negedge clk);
    check_eq("done_we", {62'd0, hilo_we_o}, 64'd3);
    check_eq("done_stall", {63'd0, stall_o}, 64'd0);
    check_eq("done_hi", {32'd0, hi_o}, {32'd0, ehi});
    check_eq("done_lo", {32'd0, lo_o}, {32'd0, elo});
    @(posedge clk); #1;
    start_i = 1'b0;
    @(negedge clk);
    check_eq("after_we", {62'd0, hilo_we_o}, 64'd0);
    check_eq("after_stall", {63'd0, stall_o}, 64'd0);
  endtask

  initial begin
    logic [1:0]  rop;
    logic [31:0] ra;
    logic [31:0] rb;
    int          rext;
    n_vec       = 0;
    n_err       = 0;
    rst         = 1'b1;
    start_i     = 1'b0;
    op_i        = 2'b00;
    srca_i      = 32'd0;
    srcb_i      = 32'd0;
    flush_i     = 1'b0;
    stall_ext_i = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_stall", {63'd0, stall_o}, 64'd0);
    check_eq("rst_we", {62'd0, hilo_we_o}, 64'd0);
    check_eq("rst_hi", {32'd0, hi_o}, 64'd0);
    check_eq("rst_lo", {32'd0, lo_o}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Directed cases
    do_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);  // MULTU
    do_op(2'b00, 32'hFFFF_FFFD, 32'h0000_0005, 0);  // MULT -3*5
    do_op(2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 0);  // DIV -7/2
    do_op(2'b11, 32'd100, 32'd7, 0);                // DIVU 100/7
    do_op(2'b11, 32'h0000_1234, 32'd0, 0);          // DIVU by zero
    do_op(2'b10, 32'h8000_0005, 32'd0, 0);          // DIV by zero
    do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0);  // DIV overflow
    do_op(2'b10, 32'd7, 32'hFFFF_FFFE, 3);          // DIV 7/-2 with external stall
    do_op(2'b11, 32'hFFFF_FFFF, 32'h8000_0001, 0);  // DIVU large divisor
    do_op(2'b00, 32'h8000_0000, 32'h8000_0000, 3);  // MULT extremes, external stall

    // Flush mid-divide at T+10: no write ever, stall drops the next cycle.
    @(posedge clk); #1;
    start_i = 1'b1; op_i = 2'b10; srca_i = 32'd1000; srcb_i = 32'd3;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
    end
    flush_i = 1'b1;
    start_i = 1'b0;
    @(negedge clk);
    check_eq("flush_cyc_we", {62'd0, hilo_we_o}, 64'd0);
    @(posedge clk); #1;
    flush_i = 1'b0;
    begin
      int we_seen;
      int stall_seen;
      we_seen = 0;
      stall_seen = 0;
      for (int k = 0; k < 40; k++) begin
        @(negedge clk);
        if (hilo_we_o != 2'b00) we_seen++;
        if (stall_o) stall_seen++;
      end
      check_eq("flush_no_we", 64'(we_seen), 64'd0);
      check_eq("flush_no_stall", 64'(stall_seen), 64'd0);
    end

    // Flush in DONE of a multiply suppresses the write.
    @(posedge clk); #1;
    start_i = 1'b1; op_i = 2'b01; srca_i = 32'd9; srcb_i = 32'd9;
    repeat (2) begin
      @(posedge clk); #1;
    end
    flush_i = 1'b1;
    @(negedge clk);
    check_eq("flush_done_we", {62'd0, hilo_we_o}, 64'd0);
    @(posedge clk); #1;
    flush_i = 1'b0;
    start_i = 1'b0;
    @(negedge clk);
    check_eq("flush_done_after_we", {62'd0, hilo_we_o}, 64'd0);
    check_eq("flush_done_after_stall", {63'd0, stall_o}, 64'd0);

    // start together with flush in IDLE is ignored.
    @(posedge clk); #1;
    start_i = 1'b1; flush_i = 1'b1; op_i = 2'b00; srca_i = 32'd2; srcb_i = 32'd3;
    @(negedge clk);
    check_eq("idle_flush_stall", {63'd0, stall_o}, 64'd0);
    @(posedge clk); #1;
    start_i = 1'b0; flush_i = 1'b0;
    @(negedge clk);
    check_eq("idle_flush_next_stall", {63'd0, stall_o}, 64'd0);
    check_eq("idle_flush_next_we", {62'd0, hilo_we_o}, 64'd0);

    // Randomised operations
    for (int i = 0; i < 40; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = $urandom;
      if ($urandom_range(0, 5) == 0) rb = 32'd0;
      else if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(1, 20));
      rext = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
      do_op(rop, ra, rb, rext);
    end

    // Reset mid-divide: no write, outputs return to reset values.
    @(posedge clk); #1;
    start_i = 1'b1; op_i = 2'b11; srca_i = 32'd12345; srcb_i = 32'd11;
    repeat (5) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    start_i = 1'b0;
    @(negedge clk);
    check_eq("rst_mid_we", {62'd0, hilo_we_o}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_eq("rst_mid_stall", {63'd0, stall_o}, 64'd0);
    check_eq("rst_mid_hi", {32'd0, hi_o}, 64'd0);
    check_eq("rst_mid_lo", {32'd0, lo_o}, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
